serial_logical_neq: RTL

- Bit-serial inequality comparator.
- Accepts operands A and B as a stream of K-bit beats, LSB beat first, over N/K accepted beats.
- Produces one registered result, c = 1 when A ≠ B, through a valid/ready output handshake.
- Sequential counterpart to the parallel NEQ units: it sits on the receiving end of operand serializers in the BasicCombinationalLogic datapath.

---
 rtl/serial_logical_neq_pkg.sv | 18 +
 rtl/serial_neq_beat_counter.sv | 39 +++
 rtl/serial_logical_neq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_logical_neq_pkg.sv
// rtl/serial_logical_neq_pkg.sv - shared types and sizing helpers for the bit-serial NEQ comparator
package serial_logical_neq_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      RESULT  = 1'b1
   } neq_state_t;

   function automatic int beats(input int n, input int k);
      return n / k;
   endfunction

   // A single-beat frame still needs a 1-bit counter so the port never collapses to zero width.
   function automatic int cnt_w(input int b);
      return (b <= 1) ? 1 : $clog2(b);
   endfunction

endpackage

// File: rtl/serial_neq_beat_counter.sv
// rtl/serial_neq_beat_counter.sv - modulo-BEATS beat counter with last-beat flag
module serial_neq_beat_counter
   import serial_logical_neq_pkg::*;
#(
   parameter int BEATS = 4,
   parameter int W     = cnt_w(BEATS)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         last
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign last = (cnt_q == W'(BEATS - 1));
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = last ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_logical_neq.sv
// rtl/serial_logical_neq.sv - bit-serial A != B comparator with valid/ready result handshake
// Optional first-mismatch beat index output enabled by SERIAL_NEQ_MISMATCH_IDX_EN.
module serial_logical_neq
   import serial_logical_neq_pkg::*;
#(
   parameter int N = 8,
   parameter int K = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 clear,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [K-1:0]                         a_beat,
   input  logic [K-1:0]                         b_beat,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 c
`ifdef SERIAL_NEQ_MISMATCH_IDX_EN
   ,
   output logic [cnt_w(beats(N, K))-1:0]       mismatch_idx
`endif
);

   localparam int BEATS = beats(N, K);
   localparam int CW    = cnt_w(BEATS);

   if (N < 1 || K < 1 || K > N || (N % K) != 0) begin : g_bad_cfg
      $error("serial_logical_neq: need N >= 1, 1 <= K <= N and N %% K == 0");
   end

   neq_state_t    state_q;
   logic          diff_q;
   logic          c_q;
   logic          out_valid_q;

   logic          accept;
   logic          beat_diff;
   logic [CW-1:0] cnt;
   logic          last;

   assign in_ready  = (state_q == COLLECT);
   assign accept    = in_valid && in_ready;
   assign beat_diff = |(a_beat ^ b_beat);
   assign out_valid = out_valid_q;
   assign c         = c_q;

   // Counter shares clear priority with the FSM so an aborted frame restarts at beat 0.
   serial_neq_beat_counter #(
      .BEATS (BEATS),
      .W     (CW)
   ) u_beat_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (accept),
      .clr   (clear),
      .cnt   (cnt),
      .last  (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         diff_q      <= 1'b0;
         c_q         <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (clear) begin
         state_q     <= COLLECT;
         diff_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (accept) begin
                  if (last) begin
                     c_q         <= diff_q | beat_diff;
                     out_valid_q <= 1'b1;
                     diff_q      <= 1'b0;
                     state_q     <= RESULT;
                  end else begin
                     diff_q <= diff_q | beat_diff;
                  end
               end
            end
            RESULT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= COLLECT;
               end
            end
            default: begin
               state_q <= COLLECT;
            end
         endcase
      end
   end

`ifdef SERIAL_NEQ_MISMATCH_IDX_EN
   logic [CW-1:0] first_q;
   logic [CW-1:0] mismatch_idx_q;

   // diff_q doubles as "a mismatch was already captured in this frame".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q        <= '0;
         mismatch_idx_q <= '0;
      end else if (clear) begin
         first_q <= '0;
      end else if (accept) begin
         if (last) begin
            mismatch_idx_q <= diff_q ? first_q : (beat_diff ? cnt : '0);
            first_q        <= '0;
         end else if (beat_diff && !diff_q) begin
            first_q <= cnt;
         end
      end
   end

   assign mismatch_idx = mismatch_idx_q;
`else
   logic unused_cnt;
   assign unused_cnt = ^cnt;
`endif

endmodule
